fnd_scan_driver: RTL and testbench

Time-multiplexed 4-digit common-anode 7-segment driver that consumes the stopwatch's packed 20-bit BCD `value` bus and turns it into anode, segment and decimal-point drive.
- Selects a 4-digit window out of the 5 packed digits.
- Snapshots the value once per scan frame so digits never tear.
- Inserts a ghosting blank at each digit slot start.
- Supports whole-display blinking for LAP indication.

---
 rtl/fnd_scan_driver.sv | 148 ++++++++++++++
 tb/tb_fnd_scan_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
//
// Time-multiplexed 4-digit common-anode 7-segment driver for the stopwatch.
// Takes the packed 5-digit BCD value, shows a 4-digit window of it, snapshots
// the value once per scan frame so digits never tear, blanks all anodes for a
// few clocks at the start of every digit slot to suppress ghosting, and can
// blink the whole display.
//
// Ports:
//   clk       system clock (only clock)
//   reset     synchronous, active-high
//   value     packed BCD: [3:0]=min10 [7:4]=min1 [11:8]=sec10 [15:12]=sec1 [19:16]=csec10
//   window    0 = MM.SS, 1 = M.SS.c (sampled at frame boundaries only)
//   blank_lz  leading-zero blanking of min10 in window 0
//   blink     force display dark during the off blink phase
//   an        anodes, active-low, an[3] leftmost
//   seg       {g,f,e,d,c,b,a}, active-low
//   dp        decimal point, active-low
module fnd_scan_driver #(
    parameter int unsigned CLOCK_FREQ  = 50_000_000,
    parameter int unsigned PRESCALER   = CLOCK_FREQ / 4000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned BLINK_TICKS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] value,
    input  logic        window,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam int unsigned PH_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALER - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [19:0]      val_q;
    logic             win_q;
    logic [PH_W-1:0]  ph_cnt;
    logic             phase;

    logic             tick;
    logic [3:0]       nib;
    logic             dp_lit;
    logic             lz;
    logic [6:0]       glyph;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign tick = (cnt == CNT_LAST);

    always_comb begin
        nib    = '0;
        dp_lit = 1'b0;
        glyph  = 7'b0111111;
        an_d   = '1;

        if (!win_q) begin
            case (idx)
                2'd3:    nib = val_q[3:0];
                2'd2:    nib = val_q[7:4];
                2'd1:    nib = val_q[11:8];
                default: nib = val_q[15:12];
            endcase
            dp_lit = (idx == 2'd2);
        end else begin
            case (idx)
                2'd3:    nib = val_q[7:4];
                2'd2:    nib = val_q[11:8];
                2'd1:    nib = val_q[15:12];
                default: nib = val_q[19:16];
            endcase
            dp_lit = (idx == 2'd3) || (idx == 2'd1);
        end

        case (nib)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase

        // Leading zero only ever applies to the min10 slot of window 0.
        lz = !win_q && blank_lz && (val_q[3:0] == 4'd0) && (idx == 2'd3);

        if (lz || (cnt < CNT_BLANK) || (blink && phase)) begin
            an_d = '1;
        end else begin
            an_d = ~(4'b0001 << idx);
        end

        seg_d = lz ? 7'h7F : glyph;
        dp_d  = lz ? 1'b1 : ~dp_lit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            val_q  <= '0;
            win_q  <= 1'b0;
            ph_cnt <= '0;
            phase  <= 1'b0;
            an     <= '1;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;

            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                // Snapshot at the frame boundary so the new frame starts at idx=0 with it.
                if (idx == 2'd3) begin
                    val_q <= value;
                    win_q <= window;
                end
                if (ph_cnt == PH_LAST) begin
                    ph_cnt <= '0;
                    phase  <= ~phase;
                end else begin
                    ph_cnt <= ph_cnt + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Testbench for fnd_scan_driver: stimulus process pushes the expected
// registered outputs for each upcoming edge into a queue; a monitor process
// pops and compares them shortly after every rising edge.
module tb_fnd_scan_driver;

    localparam int P  = 8;
    localparam int BC = 2;
    localparam int BT = 4;
    localparam int FR = 4 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] value = '0;
    logic        window = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    fnd_scan_driver #(
        .CLOCK_FREQ (32000),
        .PRESCALER  (P),
        .BLANK_CYC  (BC),
        .BLINK_TICKS(BT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .window  (window),
        .blank_lz(blank_lz),
        .blink   (blink),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         care_seg;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: cycles since reset and the per-frame snapshot.
    int          k = 0;
    int          cyc = 0;
    logic [19:0] snap_val = '0;
    logic        snap_win = 1'b0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Predict the outputs for the next edge from current inputs, then wait one cycle.
    task automatic step();
        exp_t       e;
        int         cnt_, slot, p, ph;
        logic [3:0] nib;
        bit         lz, lit;
        e.cyc = cyc;
        if (reset) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.care_seg = 1'b1;
            k = 0; snap_val = '0; snap_win = 1'b0;
        end else begin
            cnt_ = k % P;
            slot = k / P;
            p    = slot % 4;
            ph   = (slot / BT) % 2;
            nib  = snap_win ? snap_val[4*(4-p) +: 4] : snap_val[4*(3-p) +: 4];
            lit  = snap_win ? (p == 3 || p == 1) : (p == 2);
            lz   = !snap_win && blank_lz && (snap_val[3:0] == 4'd0) && (p == 3);
            e.an = 4'hF;
            if (!(lz || cnt_ < BC || (blink && ph == 1))) e.an[p] = 1'b0;
            e.seg      = lz ? 7'h7F : glyph[nib];
            e.dp       = lz ? 1'b1 : !lit;
            e.care_seg = lz || (e.an != 4'hF);
            if (k % FR == FR - 1) begin
                snap_val = value;
                snap_win = window;
            end
            k++;
        end
        sb.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while ((k % FR) != pos && guard < 2 * FR) begin
            step();
            guard++;
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (an !== e.an) begin
                    n_bad++;
                    $display("FAIL an cyc=%0d got=%b want=%b", e.cyc, an, e.an);
                end
                if (e.care_seg) begin
                    n_cmp++;
                    if (seg !== e.seg) begin
                        n_bad++;
                        $display("FAIL seg cyc=%0d an=%b got=%b want=%b", e.cyc, an, seg, e.seg);
                    end
                    n_cmp++;
                    if (dp !== e.dp) begin
                        n_bad++;
                        $display("FAIL dp cyc=%0d an=%b got=%b want=%b", e.cyc, an, dp, e.dp);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and basic scan sequence
        reset = 1'b1; value = '0; window = 1'b0; blank_lz = 1'b0; blink = 1'b0;
        step(); step();
        reset = 1'b0;
        run(4 * FR);

        // Window 0: 12:45.7
        value = {4'h7, 4'h5, 4'h4, 4'h2, 4'h1};
        run(3 * FR);

        // Window 1 switched mid-frame
        run_to(10);
        window = 1'b1;
        run(3 * FR);

        // Leading-zero blank plus invalid min1 digit
        window = 1'b0;
        blank_lz = 1'b1;
        value = {4'h3, 4'h9, 4'h5, 4'hC, 4'h0};
        run(3 * FR);
        blank_lz = 1'b0;
        run(2 * FR);

        // Blink
        value = 20'h98765;
        blink = 1'b1;
        run(6 * FR);
        blink = 1'b0;
        run(2 * FR);

        // Reset mid-slot at idx=2, cnt=5
        run_to(2 * P + 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        value = 20'h0;
        run(3 * FR);

        // Randomized traffic
        repeat (60) begin
            value = 20'($urandom);
            if ($urandom_range(0, 1) == 1) value[3:0] = 4'd0;
            if ($urandom_range(0, 2) == 0) window = 1'($urandom);
            if ($urandom_range(0, 2) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 2) == 0) blink = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            run($urandom_range(5, 60));
        end
        blink = 1'b0;
        run(FR);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
